// File: rtl/avgpool_seq.sv
// rtl/avgpool_seq.sv - sequencer for the fp16 average-pooling datapath
// Purpose: accepts WIN_SIZE fp16 elements per window, issues each one with the
//   running partial sum to a serial accumulator, then launches the divide and
//   returns one fp16 average per window.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start / busy / done       window control and status, avg_out valid on done
//   avg_out                   fp16 window average, held until next done
//   in_data/in_valid/in_ready upstream element stream
//   acc_tmp_sum/acc_data      operands presented to the accumulator / divider
//   acc_nd / acc_rdy, acc_sum accumulator issue strobe / result
//   div_en / div_rdy, div_result divider launch strobe / result
//   err                       sticky watchdog error
// Optional feature: define AVGPOOL_TIMEOUT_EN to enable the WAIT_SUM/WAIT_DIV
//   watchdog (TO_CYC cycles); otherwise err is tied low.
module avgpool_seq #(
  parameter int WIN_SIZE = 169,
  parameter int CNT_W    = 12,
  parameter int TO_CYC   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] avg_out,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] acc_tmp_sum,
  output logic [15:0] acc_data,
  output logic        acc_nd,
  input  logic        acc_rdy,
  input  logic [15:0] acc_sum,
  output logic        div_en,
  input  logic        div_rdy,
  input  logic [15:0] div_result,
  output logic        err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FEED     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_SUM = 3'd3;
  localparam logic [2:0] S_DIV      = 3'd4;
  localparam logic [2:0] S_WAIT_DIV = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_SIZE);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

`ifdef AVGPOOL_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  logic [TO_W-1:0] to_cnt;
  logic            waiting;
  logic            leaving;
  logic            expired;

  // to_cnt is the number of completed cycles spent in the current wait state;
  // it clears whenever the state is left or a non-wait state is occupied.
  assign waiting = (state == S_WAIT_SUM) || (state == S_WAIT_DIV);
  assign leaving = ((state == S_WAIT_SUM) && acc_rdy) || ((state == S_WAIT_DIV) && div_rdy);
  assign expired = waiting && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (waiting && !leaving && !expired) to_cnt <= to_cnt + TO_W'(1);
      else                                 to_cnt <= '0;
      if (expired) err <= 1'b1;
    end
  end
`else
  logic unused_to;
  assign unused_to = (TO_CYC > 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b0;
      acc_nd      <= 1'b0;
      div_en      <= 1'b0;
      avg_out     <= 16'h0000;
      acc_data    <= 16'h0000;
      acc_tmp_sum <= 16'h0000;
    end else begin
      // strobes are single-cycle unless re-armed below
      done   <= 1'b0;
      acc_nd <= 1'b0;
      div_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt         <= '0;
            acc_tmp_sum <= 16'h0000;
            busy        <= 1'b1;
            in_ready    <= 1'b1;
            state       <= S_FEED;
          end
        end
        S_FEED: begin
          if (in_valid && in_ready) begin
            acc_data <= in_data;
            if (cnt != WIN_LAST) cnt <= cnt + CNT_W'(1);
            in_ready <= 1'b0;
            acc_nd   <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT_SUM;
        S_WAIT_SUM: begin
          if (acc_rdy) begin
            acc_tmp_sum <= acc_sum;
            if (cnt == WIN_LAST) begin
              state <= S_DIV;
            end else begin
              in_ready <= 1'b1;
              state    <= S_FEED;
            end
          end
        end
        S_DIV: begin
          // final sum goes out on acc_data together with the divide strobe
          acc_data <= acc_tmp_sum;
          div_en   <= 1'b1;
          state    <= S_WAIT_DIV;
        end
        S_WAIT_DIV: begin
          if (div_rdy) begin
            avg_out <= div_result;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
`ifdef AVGPOOL_TIMEOUT_EN
      // watchdog abort overrides the normal wait-state handling
      if (expired) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        done     <= 1'b0;
        in_ready <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_avgpool_seq.sv
// tb/tb_avgpool_seq.sv - directed self-checking bench for avgpool_seq
module tb_avgpool_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic [15:0] in_data = 16'h0, acc_sum = 16'h0, div_result = 16'h0;
  logic        in_valid = 1'b0, acc_rdy = 1'b0, div_rdy = 1'b0;

  logic        busy, done, in_ready, acc_nd, div_en, err;
  logic [15:0] avg_out, acc_tmp_sum, acc_data;
  logic        busy1, done1, in_ready1, acc_nd1, div_en1, err1;
  logic [15:0] avg1, tmp1, data1;

  int n_cmp = 0, n_bad = 0;
  int nd_cnt = 0, div_cnt = 0, done_cnt = 0, nd1_cnt = 0;
  logic [15:0] elem [4];
  logic [15:0] sums [4];
  logic [15:0] avg_exp;

  always #5 clk = ~clk;

  avgpool_seq #(.WIN_SIZE(4), .CNT_W(4), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .avg_out(avg_out),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .acc_tmp_sum(acc_tmp_sum), .acc_data(acc_data), .acc_nd(acc_nd),
    .acc_rdy(acc_rdy), .acc_sum(acc_sum), .div_en(div_en), .div_rdy(div_rdy),
    .div_result(div_result), .err(err));

  avgpool_seq #(.WIN_SIZE(1), .CNT_W(2), .TO_CYC(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .avg_out(avg1),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .acc_tmp_sum(tmp1), .acc_data(data1), .acc_nd(acc_nd1),
    .acc_rdy(acc_rdy), .acc_sum(acc_sum), .div_en(div_en1), .div_rdy(div_rdy),
    .div_result(div_result), .err(err1));

  always @(negedge clk) begin
    if (acc_nd)  nd_cnt++;
    if (div_en)  div_cnt++;
    if (done)    done_cnt++;
    if (acc_nd1) nd1_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_window(input bit bp, input bit stray);
    int nd0, dv0, dn0, d;
    logic [15:0] tmp_exp;
    nd0 = nd_cnt; dv0 = div_cnt; dn0 = done_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_in_feed", in_ready, 1);
    if (stray) begin
      start = 1'b1; acc_rdy = 1'b1; acc_sum = 16'hDEAD; div_rdy = 1'b1; div_result = 16'hBEEF;
      @(negedge clk);
      start = 1'b0; acc_rdy = 1'b0; div_rdy = 1'b0;
      chk("stray_no_issue", acc_nd, 0);
      chk("stray_still_feed", in_ready, 1);
      chk("stray_no_done", done, 0);
    end
    for (int i = 0; i < 4; i++) begin
      in_data = elem[i];
      for (int k = 0; k < 64 && !acc_nd; k++) begin
        in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b0;
      tmp_exp = (i == 0) ? 16'h0000 : sums[i-1];
      chk("acc_nd_issue", acc_nd, 1);
      chk("acc_data_elem", acc_data, elem[i]);
      chk("acc_tmp_sum", acc_tmp_sum, tmp_exp);
      acc_sum = sums[i];
      d = bp ? int'($urandom_range(0, 6)) : 0;
      @(negedge clk);
      chk("acc_nd_one_cycle", acc_nd, 0);
      for (int k = 0; k < d; k++) begin
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      in_valid = 1'b0;
      acc_rdy = 1'b1; @(negedge clk); acc_rdy = 1'b0;
    end
    for (int k = 0; k < 8 && !div_en; k++) @(negedge clk);
    chk("div_en_seen", div_en, 1);
    chk("acc_data_final_sum", acc_data, sums[3]);
    div_result = avg_exp; div_rdy = 1'b1; @(negedge clk); div_rdy = 1'b0;
    chk("done_pulse", done, 1);
    chk("avg_out", avg_out, avg_exp);
    chk("busy_low_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("acc_nd_count", nd_cnt - nd0, 4);
    chk("div_en_count", div_cnt - dv0, 1);
    chk("done_count", done_cnt - dn0, 1);
  endtask

  initial begin
    int nd0, k;
    repeat (2) @(negedge clk);
    // reset values
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tmp_sum", acc_tmp_sum, 16'h0000);
    chk("rst_avg_out", avg_out, 16'h0000);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // four 1.0 elements
    for (int i = 0; i < 4; i++) elem[i] = 16'h3C00;
    sums[0] = 16'h3C00; sums[1] = 16'h4000; sums[2] = 16'h4200; sums[3] = 16'h4400;
    avg_exp = 16'h3C00;
    run_window(1'b0, 1'b0);

    // reset mid-FEED with a partial sum already latched
    start = 1'b1; @(negedge clk); start = 1'b0;
    in_data = 16'h4000; in_valid = 1'b1; @(negedge clk); in_valid = 1'b0;
    acc_sum = 16'h4000; @(negedge clk);
    acc_rdy = 1'b1; @(negedge clk); acc_rdy = 1'b0;
    chk("mid_feed_ready", in_ready, 1);
    chk("mid_feed_tmp", acc_tmp_sum, 16'h4000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_tmp", acc_tmp_sum, 16'h0000);
    chk("async_rst_data", acc_data, 16'h0000);
    chk("async_rst_avg", avg_out, 16'h0000);
    @(negedge clk); rst = 1'b0;
    nd0 = nd_cnt;
    in_valid = 1'b1; repeat (3) @(negedge clk); in_valid = 1'b0;
    chk("idle_after_rst_ready", in_ready, 0);
    chk("idle_after_rst_busy", busy, 0);
    chk("idle_no_issue", nd_cnt - nd0, 0);

    // backpressure with distinct elements: 1,2,3,4 -> sums 1,3,6,10, avg 2.5
    elem[0] = 16'h3C00; elem[1] = 16'h4000; elem[2] = 16'h4200; elem[3] = 16'h4400;
    sums[0] = 16'h3C00; sums[1] = 16'h4200; sums[2] = 16'h4600; sums[3] = 16'h4900;
    avg_exp = 16'h4100;
    run_window(1'b1, 1'b0);
    run_window(1'b1, 1'b0);

    // stray controls in IDLE, then start/acc_rdy/div_rdy while busy
    acc_rdy = 1'b1; div_rdy = 1'b1; acc_sum = 16'h1234; div_result = 16'h5678;
    @(negedge clk);
    acc_rdy = 1'b0; div_rdy = 1'b0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_done", done, 0);
    chk("stray_idle_avg", avg_out, 16'h4100);
    run_window(1'b0, 1'b1);

    // single-element window
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_in_ready", in_ready1, 1);
    in_data = 16'h4500; in_valid = 1'b1; @(negedge clk); in_valid = 1'b0;
    chk("w1_acc_nd", acc_nd1, 1);
    chk("w1_acc_data", data1, 16'h4500);
    chk("w1_tmp_sum", tmp1, 16'h0000);
    acc_sum = 16'h4500; @(negedge clk);
    acc_rdy = 1'b1; @(negedge clk); acc_rdy = 1'b0;
    for (k = 0; k < 8 && !div_en1; k++) @(negedge clk);
    chk("w1_div_en", div_en1, 1);
    chk("w1_final_sum", data1, 16'h4500);
    div_result = 16'h4500; div_rdy = 1'b1; @(negedge clk); div_rdy = 1'b0;
    chk("w1_done", done1, 1);
    chk("w1_avg_out", avg1, 16'h4500);
    chk("w1_nd_count", nd1_cnt, 1);
    chk("main_unaffected", busy, 0);

`ifdef AVGPOOL_TIMEOUT_EN
    begin
      int dn0;
      dn0 = done_cnt;
      start = 1'b1; @(negedge clk); start = 1'b0;
      in_data = 16'h3C00; in_valid = 1'b1; @(negedge clk); in_valid = 1'b0;
      chk("to_issue", acc_nd, 1);
      for (k = 0; k < 40 && !err; k++) @(negedge clk);
      chk("to_err_latency", k, 17);
      chk("to_err", err, 1);
      chk("to_busy", busy, 0);
      chk("to_no_done", done_cnt - dn0, 0);
      elem[0] = 16'h3C00; elem[1] = 16'h3C00; elem[2] = 16'h3C00; elem[3] = 16'h3C00;
      sums[0] = 16'h3C00; sums[1] = 16'h4000; sums[2] = 16'h4200; sums[3] = 16'h4400;
      avg_exp = 16'h3C00;
      run_window(1'b0, 1'b0);
      chk("to_err_sticky", err, 1);
    end
`else
    chk("err_tied_low", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
